xadc_drp_reader: RTL and testbench
==================================

# xadc_drp_reader

Sequencing and conversion stage between the XADC wizard DRP port and the OLED display controller. On each XADC end-of-conversion it issues one DRP read from a fixed four-channel auxiliary round-robin and captures the 12-bit code. It scales the code to millivolts and converts it to four BCD digits with an iterative double-dabble. It presents digits, channel number and an LED byte to the display path with a one-cycle valid strobe.

## Interface
- `DRP_TIMEOUT`, default 255: cycles to wait for `drdy` after a request before abandoning the read.
- `CLAMP_CODE`, default 4093: codes at or above this value display as 1.000 V.
- `CLK` in 1: system clock, 100 MHz, also drives the XADC DCLK.
- `RST` in 1: reset; synchronous, active-high.
- `eoc` in 1: XADC end-of-conversion pulse.
- `drdy` in 1: XADC DRP data-ready.
- `do_in` in 16: XADC DRP read data; code is `do_in[15:4]`.
- `sel_sw` in 4: channel whose code low byte drives `led`.
- `daddr` out 7: DRP address.
- `den` out 1: DRP enable, one-cycle pulse.
- `dig3`, `dig2`, `dig1`, `dig0` out 4 each: BCD volts digit, then tenths, hundredths and thousandths of a volt.
- `channel` out 4: `daddr[3:0]` of the displayed sample.
- `valid` out 1: one-cycle strobe when the digit, channel and LED outputs update.
- `timeout` out 1: one-cycle strobe when a DRP read is abandoned.
- `led` out 8: `code[7:0]` of the most recent sample from channel `sel_sw`.

## Operation
- Address sequence: 0x10 → 0x18 → 0x19 → 0x11 → 0x10. Any other value reloads 0x10.
- FSM states and transitions:
  - IDLE: `eoc`=1 → REQ.
  - REQ: `den`=1 with the current `daddr` → WAIT.
  - WAIT: `drdy`=1 latches `code` → SCALE. Timeout counter reaching `DRP_TIMEOUT` → DONE with `timeout`=1.
  - SCALE: if `code` ≥ `CLAMP_CODE`, mv=1000; else mv=(code×1000)>>12, truncated, range 0..999. → CONV.
  - CONV: 10 iterations of double-dabble on the 10-bit mv (add-3 to each nibble ≥5, then shift) → DONE.
  - DONE: without timeout, update `dig*`, `channel` and `led`, and pulse `valid`. In either case advance `daddr` → IDLE.
- Arithmetic: the product needs 22 bits. Use an unsigned shift-add or a single multiplier. No rounding.
- `led` updates only when `channel` equals `sel_sw`. Otherwise it holds.
- `eoc` outside IDLE is ignored. No queuing and no counting.
- `drdy` outside WAIT is ignored.
- `timeout` path: digits, `channel` and `led` keep their prior values. The address still advances, so a dead channel cannot stall the scan.
- `drdy` and the timeout terminal count in the same cycle: `drdy` wins.

## Timing
- All outputs registered.
- Reset values: `daddr`=0x10, `den`=0, `dig*`=0, `channel`=0, `valid`=0, `timeout`=0, `led`=0, state IDLE.
- `RST` mid-operation: next cycle is IDLE with reset values. A late `drdy` from the aborted read is ignored.
- Handshake timing:
  - `eoc` sampled at cycle 0 → `den`=1 during cycle 1.
  - `drdy` sampled at cycle k → SCALE k+1, CONV k+2..k+11, `valid`=1 during k+12.
- Read-to-valid latency: 12 cycles after `drdy`. Total busy time is far below the XADC conversion period, so no `eoc` is lost in normal sequencer mode.
- Timeout: `timeout`=1 exactly `DRP_TIMEOUT`+1 cycles after `den`.

## Structure
- Shared package `xadc_pkg`:
  - address constants 0x10, 0x18, 0x19 and 0x11;
  - the next-address function;
  - FSM state encoding;
  - `CLAMP_CODE` default.
- Sub-module `bin2bcd_seq` handles the iterative double-dabble. Ports: `CLK`, `RST`, `start`, `bin[9:0]`, `busy`, `done`, and four BCD nibbles. Its 10-cycle latency is fixed.
- Top-level integration: `dig*` feeds the OLED controller zero-extended to 8 bits.

## Test plan
- Mid-scale: `do_in`=0x8000 on 0x10 → `dig`=0,5,0,0; `channel`=0; `valid` 12 cycles after `drdy`.
- Clamp boundary:
  - code 4093 (`do_in`=0xFFD0) → 1,0,0,0;
  - code 4092 → 0,9,9,9;
  - code 0 → 0,0,0,0.
- Scan order: four `eoc` pulses → `daddr` during `den` = 0x10, 0x18, 0x19, 0x11, then wrap to 0x10.
- LED select: `sel_sw`=8, code 0xABC on 0x18 → `led`=0xBC. A later sample on 0x19 leaves `led` at 0xBC.
- Missing `drdy`: `timeout` at `den`+256 cycles, `valid` stays 0, digits unchanged, next `den` uses the next address. `drdy` arriving at the same cycle as the terminal count → normal `valid`.
- Reset and busy: `RST` asserted during CONV → reset values next cycle and the late `drdy` is ignored. An `eoc` pulsed during WAIT produces no second `den`.

Source files
------------

// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP reader: auxiliary channel
// addresses, scan order, FSM encoding and default parameters.
package xadc_pkg;

    // DRP status-register addresses of the scanned auxiliary channels
    localparam logic [6:0] ADDR_VAUX0 = 7'h10;
    localparam logic [6:0] ADDR_VAUX8 = 7'h18;
    localparam logic [6:0] ADDR_VAUX9 = 7'h19;
    localparam logic [6:0] ADDR_VAUX1 = 7'h11;

    localparam int CLAMP_CODE_DEF  = 4093;
    localparam int DRP_TIMEOUT_DEF = 255;

    // Number of double-dabble iterations for a 10-bit millivolt value
    localparam int BCD_ITERS = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SCALE,
        ST_CONV,
        ST_DONE
    } state_t;

    // Round-robin successor; anything off the ring restarts at VAUX0
    function automatic logic [6:0] next_addr(input logic [6:0] a);
        logic [6:0] n;
        unique case (1'b1)
            (a == ADDR_VAUX0): n = ADDR_VAUX8;
            (a == ADDR_VAUX8): n = ADDR_VAUX9;
            (a == ADDR_VAUX9): n = ADDR_VAUX1;
            (a == ADDR_VAUX1): n = ADDR_VAUX0;
            default:           n = ADDR_VAUX0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 10-bit binary to four BCD digits.
// Ports: CLK, RST (sync, active-high), start, bin[9:0] in;
//        busy, done (1-cycle pulse), bcd3..bcd0 out.
// A start taken at cycle t raises done at cycle t+10 with final digits.
module bin2bcd_seq
    import xadc_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic [9:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] bcd3,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0
);

    localparam logic [3:0] LAST_ITER = 4'(BCD_ITERS - 1);

    // [25:10] BCD accumulator, [9:0] binary still to shift in
    logic [25:0] work_q;
    logic [25:0] step_in;
    logic [25:0] step_out;
    logic [3:0]  iter_q;
    logic        busy_q;
    logic        done_q;

    function automatic logic [25:0] dd_step(input logic [25:0] v);
        logic [25:0] t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            if (t[10+4*i +: 4] >= 4'd5) begin
                t[10+4*i +: 4] = t[10+4*i +: 4] + 4'd3;
            end
        end
        return {t[24:0], 1'b0};
    endfunction

    // The first iteration is folded into the load so that ten
    // iterations complete ten cycles after start.
    always_comb begin
        step_in = work_q;
        if (start && !busy_q) begin
            step_in = {16'd0, bin};
        end
        step_out = dd_step(step_in);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            work_q <= '0;
            iter_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                work_q <= step_out;
                iter_q <= iter_q + 4'd1;
                if (iter_q == LAST_ITER) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                work_q <= step_out;
                iter_q <= 4'd1;
                busy_q <= 1'b1;
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd3 = work_q[25:22];
    assign bcd2 = work_q[21:18];
    assign bcd1 = work_q[17:14];
    assign bcd0 = work_q[13:10];

endmodule

// File: rtl/xadc_drp_reader.sv
// Reads one XADC aux channel per end-of-conversion over DRP, scales the
// 12-bit code to millivolts and publishes BCD digits for the display.
// Ports: CLK, RST (sync, active-high), eoc, drdy, do_in[15:0], sel_sw[3:0] in;
//        daddr[6:0], den, dig3..dig0, channel[3:0], valid, timeout, led[7:0] out.
// All outputs are registered; valid and timeout are one-cycle strobes.
module xadc_drp_reader
    import xadc_pkg::*;
#(
    parameter int DRP_TIMEOUT = DRP_TIMEOUT_DEF,
    parameter int CLAMP_CODE  = CLAMP_CODE_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        eoc,
    input  logic        drdy,
    input  logic [15:0] do_in,
    input  logic [3:0]  sel_sw,
    output logic [6:0]  daddr,
    output logic        den,
    output logic [3:0]  dig3,
    output logic [3:0]  dig2,
    output logic [3:0]  dig1,
    output logic [3:0]  dig0,
    output logic [3:0]  channel,
    output logic        valid,
    output logic        timeout,
    output logic [7:0]  led
);

    localparam logic [11:0] CLAMP    = 12'(CLAMP_CODE);
    localparam logic [15:0] TMO_LAST = 16'(DRP_TIMEOUT);

    state_t      state_q;
    state_t      state_d;
    logic [11:0] code_q;
    logic [15:0] tmo_cnt_q;
    logic        tmo_hit;

    logic [21:0] code_ext;
    logic [21:0] prod;
    logic [9:0]  mv;

    logic       bcd_busy;
    logic       bcd_done;
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;

    logic unused_sink;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // drdy is checked ahead of the terminal count so a reply that lands
    // on the last waiting cycle is still accepted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (eoc) state_d = ST_REQ;
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT: begin
                if (drdy) begin
                    state_d = ST_SCALE;
                end else if (tmo_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_SCALE: state_d = ST_CONV;
            ST_CONV:  if (bcd_done) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // code * 1000 as (code << 10) - (code << 4) - (code << 3)
    always_comb begin
        code_ext = {10'd0, code_q};
        prod = (code_ext << 10) - (code_ext << 4) - (code_ext << 3);
        if (code_q >= CLAMP) begin
            mv = 10'd1000;
        end else begin
            mv = prod[21:12];
        end
    end

    bin2bcd_seq u_bcd (
        .CLK   (CLK),
        .RST   (RST),
        .start (state_q == ST_SCALE),
        .bin   (mv),
        .busy  (bcd_busy),
        .done  (bcd_done),
        .bcd3  (bcd3),
        .bcd2  (bcd2),
        .bcd1  (bcd1),
        .bcd0  (bcd0)
    );

    // Strobes are set on the edge entering the state they belong to,
    // so den is high during REQ and valid/timeout during DONE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            daddr     <= ADDR_VAUX0;
            den       <= 1'b0;
            dig3      <= '0;
            dig2      <= '0;
            dig1      <= '0;
            dig0      <= '0;
            channel   <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            led       <= '0;
            code_q    <= '0;
            tmo_cnt_q <= '0;
        end else begin
            den     <= (state_q == ST_IDLE) && eoc;
            valid   <= (state_q == ST_CONV) && bcd_done;
            timeout <= (state_q == ST_WAIT) && !drdy && tmo_hit;

            // Counter reads 1 on the first WAIT cycle
            if (state_q == ST_REQ) begin
                tmo_cnt_q <= 16'd1;
            end else if (state_q == ST_WAIT) begin
                tmo_cnt_q <= tmo_cnt_q + 16'd1;
            end

            if ((state_q == ST_WAIT) && drdy) begin
                code_q <= do_in[15:4];
            end

            if ((state_q == ST_CONV) && bcd_done) begin
                dig3    <= bcd3;
                dig2    <= bcd2;
                dig1    <= bcd1;
                dig0    <= bcd0;
                channel <= daddr[3:0];
                if (daddr[3:0] == sel_sw) begin
                    led <= code_q[7:0];
                end
            end

            // Advance even after a timeout so a dead channel is skipped
            if (state_q == ST_DONE) begin
                daddr <= next_addr(daddr);
            end
        end
    end

    assign unused_sink = ^{do_in[3:0], prod[11:0], bcd_busy};

endmodule

// File: tb/tb_xadc_drp_reader.sv
// Randomized scoreboard bench for xadc_drp_reader.
// Stimulus pushes expectations; negedge monitors pop and compare.
module tb_xadc_drp_reader;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        eoc = 1'b0;
    logic        drdy = 1'b0;
    logic [15:0] do_in = '0;
    logic [3:0]  sel_sw = '0;
    logic [6:0]  daddr;
    logic        den;
    logic [3:0]  dig3, dig2, dig1, dig0;
    logic [3:0]  channel;
    logic        valid;
    logic        timeout;
    logic [7:0]  led;

    always #5 CLK = ~CLK;

    xadc_drp_reader dut (
        .CLK     (CLK),
        .RST     (RST),
        .eoc     (eoc),
        .drdy    (drdy),
        .do_in   (do_in),
        .sel_sw  (sel_sw),
        .daddr   (daddr),
        .den     (den),
        .dig3    (dig3),
        .dig2    (dig2),
        .dig1    (dig1),
        .dig0    (dig0),
        .channel (channel),
        .valid   (valid),
        .timeout (timeout),
        .led     (led)
    );

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       to;
        logic [3:0] d3, d2, d1, d0, ch;
        logic [7:0] led;
    } ev_t;
    typedef struct { ev_t ev; int cyc; } exp_t;
    typedef struct { logic [6:0] a; int cyc; } den_t;

    exp_t ev_q[$];
    den_t den_q[$];

    // Reference model state
    logic [6:0] addr_tbl[4];
    int         m_idx;
    logic [3:0] m_d3, m_d2, m_d1, m_d0, m_ch;
    logic [7:0] m_led;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    always @(negedge CLK) begin
        if (den) begin
            if (den_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL den_unexpected: got addr %h expected no den", daddr);
            end else begin
                den_t d;
                d = den_q.pop_front();
                chk("den_addr", 64'(daddr), 64'(d.a));
                chk("den_cycle", 64'(cyc), 64'(d.cyc));
            end
        end
        if (valid || timeout) begin
            ev_t a;
            a = {timeout, dig3, dig2, dig1, dig0, channel, led};
            if (ev_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL event_unexpected: got %h expected none", a);
            end else begin
                exp_t e;
                e = ev_q.pop_front();
                chk(e.ev.to ? "timeout_event" : "valid_event", 64'(a), 64'(e.ev));
                chk("event_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset(input string name);
        chk(name, {daddr, den, dig3, dig2, dig1, dig0, channel, valid, timeout, led},
            {7'h10, 1'b0, 16'h0000, 4'h0, 1'b0, 1'b0, 8'h00});
    endtask

    task automatic model_reset();
        m_idx = 0;
        m_d3 = 0; m_d2 = 0; m_d1 = 0; m_d0 = 0;
        m_ch = 0;
        m_led = 0;
    endtask

    task automatic model_sample(input logic [11:0] code);
        int c, mv;
        c = int'(code);
        mv = (c >= 4093) ? 1000 : (c * 1000) / 4096;
        m_d3 = 4'(mv / 1000);
        m_d2 = 4'((mv / 100) % 10);
        m_d1 = 4'((mv / 10) % 10);
        m_d0 = 4'(mv % 10);
        m_ch = addr_tbl[m_idx][3:0];
        if (m_ch == sel_sw) m_led = code[7:0];
    endtask

    // mode 0: normal read, 1: no drdy (timeout), 2: reset during CONV
    task automatic run_txn(input logic [11:0] code, input int mode,
                           input int dly, input bit extra);
        int dcyc;
        ev_t e;
        tick();
        eoc = 1'b1;
        den_q.push_back('{a: addr_tbl[m_idx], cyc: cyc + 1});
        tick();
        eoc = 1'b0;
        dcyc = cyc;
        if (mode == 1) begin
            e = {1'b1, m_d3, m_d2, m_d1, m_d0, m_ch, m_led};
            ev_q.push_back('{ev: e, cyc: dcyc + 256});
            for (int i = 0; i < 258; i++) begin
                tick();
                eoc = extra && (i == 3);
            end
            eoc = 1'b0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            for (int i = 0; i < dly; i++) begin
                tick();
                eoc = extra && (i == 0);
            end
            drdy = 1'b1;
            do_in = {code, 4'($urandom)};
            if (mode == 0) begin
                model_sample(code);
                e = {1'b0, m_d3, m_d2, m_d1, m_d0, m_ch, m_led};
                ev_q.push_back('{ev: e, cyc: cyc + 12});
            end
            tick();
            drdy = 1'b0;
            eoc = 1'b0;
            do_in = 16'($urandom);
            if (mode == 0) begin
                repeat (13) tick();
                m_idx = (m_idx + 1) % 4;
            end else begin
                repeat (4) tick();
                RST = 1'b1;
                tick();
                RST = 1'b0;
                check_reset("reset_mid_conv");
                model_reset();
                tick();
                drdy = 1'b1;
                do_in = {12'hFFF, 4'h0};
                tick();
                drdy = 1'b0;
                repeat (15) tick();
            end
        end
    endtask

    initial begin
        logic [11:0] code;
        int r, dly;
        bit extra;
        addr_tbl[0] = 7'h10;
        addr_tbl[1] = 7'h18;
        addr_tbl[2] = 7'h19;
        addr_tbl[3] = 7'h11;
        model_reset();

        RST = 1'b1;
        repeat (3) tick();
        check_reset("reset_state");
        RST = 1'b0;

        sel_sw = 4'd8;
        run_txn(12'h800, 0, 3, 1'b0);
        run_txn(12'd4093, 0, 1, 1'b0);
        run_txn(12'd4092, 0, 5, 1'b1);
        run_txn(12'd0, 0, 2, 1'b0);
        run_txn(12'h111, 0, 4, 1'b0);
        run_txn(12'hABC, 0, 2, 1'b0);
        run_txn(12'h123, 0, 3, 1'b0);
        run_txn(12'h456, 1, 0, 1'b1);
        run_txn(12'h7FF, 0, 255, 1'b0);
        run_txn(12'h0FE, 2, 6, 1'b0);

        for (int n = 0; n < 40; n++) begin
            code = 12'($urandom);
            if ($urandom_range(0, 3) == 0) code = 12'($urandom_range(4090, 4095));
            r = $urandom_range(0, 3);
            sel_sw = (r == 0) ? 4'($urandom) : addr_tbl[r][3:0];
            r = $urandom_range(0, 15);
            dly = (r == 2) ? 255 : $urandom_range(1, 12);
            extra = ($urandom_range(0, 3) == 0);
            run_txn(code, (r == 0) ? 1 : (r == 1) ? 2 : 0, dly, extra);
        end

        repeat (5) tick();
        chk("pending_events", 64'(ev_q.size()), 64'd0);
        chk("pending_den", 64'(den_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
